// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Definitions shared by the 4-channel TDM demultiplexer and its
//                matching multiplexer: framer state encoding, channel count
//                and default slot width.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  localparam int NUM_CH            = 4;
  localparam int TDM_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_shreg
//  Description : WIDTH-bit MSB-first serial-to-parallel shift register with a
//                bit counter. The completing bit is merged combinationally
//                into word_o so the full word is available on the same beat
//                that samples the final bit.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clr_i         - drop partial word, counter to 0
//                start_i       - din_i becomes the first (MSB) bit, counter 1
//                shift_i       - shift din_i in, counter advances
//                din_i         - serial data
//                word_o        - word formed by stored bits plus din_i
//                bit_cnt_o     - number of bits already held in this slot
//                done_o        - this shift completes the word
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_shreg #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     start_i,
  input  logic                     shift_i,
  input  logic                     din_i,
  output logic [WIDTH-1:0]         word_o,
  output logic [$clog2(WIDTH)-1:0] bit_cnt_o,
  output logic                     done_o
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear outranks start, start outranks shift
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (start_i) begin
      data_d = WIDTH'(din_i);
      cnt_d  = CNT_W'(1);
    end else if (shift_i) begin
      data_d = WIDTH'({data_q, din_i});
      cnt_d  = (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o    = WIDTH'({data_q, din_i});
  assign bit_cnt_o = cnt_q;
  assign done_o    = shift_i && (cnt_q == LAST_BIT);

endmodule
`default_nettype wire

// File: rtl/tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_4ch
//  Description : Serial 4-slot TDM frame demultiplexer. Hunts for frame_sync,
//                then deserialises slots a..d into held channel registers,
//                flagging framing violations.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                din                 - serial data, MSB of each slot first
//                din_valid           - qualifies din and frame_sync
//                frame_sync          - first bit of slot 0 of a frame
//                ch_a..ch_d          - last completed word per channel
//                ch_valid[3:0]       - per-channel completion strobe
//                frame_done          - strobe with completion of slot 3
//                sync_err            - strobe on framing violation
//                locked              - framer is in LOCK
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  ch_a,
  output logic [WIDTH-1:0]  ch_b,
  output logic [WIDTH-1:0]  ch_c,
  output logic [WIDTH-1:0]  ch_d,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int         CNT_W     = $clog2(WIDTH);
  localparam logic [1:0] LAST_SLOT = 2'(NUM_CH - 1);

  tdm_state_e       state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] ch_q [NUM_CH];
  logic [NUM_CH-1:0] ch_valid_q;
  logic             frame_done_q;
  logic             sync_err_q;

  logic             sh_clr, sh_start, sh_shift, sh_done;
  logic [WIDTH-1:0] sh_word;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_start;

  // Slot 0 with no bits held is the only place frame_sync is legal in LOCK
  assign frame_start = (slot_q == 2'd0) && (bit_cnt == '0);

  always_comb begin
    sh_clr   = 1'b0;
    sh_start = 1'b0;
    sh_shift = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        sh_start = frame_sync;
      end else if (frame_start) begin
        // missing sync at frame start drops the beat and the partial state
        sh_start = frame_sync;
        sh_clr   = !frame_sync;
      end else begin
        // unexpected sync restarts a frame with this beat as its first bit
        sh_start = frame_sync;
        sh_shift = !frame_sync;
      end
    end
  end

  tdm_slot_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (sh_clr),
    .start_i   (sh_start),
    .shift_i   (sh_shift),
    .din_i     (din),
    .word_o    (sh_word),
    .bit_cnt_o (bit_cnt),
    .done_o    (sh_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            if (frame_sync) begin
              state_q <= LOCK;
              slot_q  <= '0;
            end
          end
          LOCK: begin
            if (frame_start && !frame_sync) begin
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
              slot_q     <= '0;
            end else if (!frame_start && frame_sync) begin
              sync_err_q <= 1'b1;
              slot_q     <= '0;
            end else if (sh_done) begin
              ch_q[slot_q]       <= sh_word;
              ch_valid_q[slot_q] <= 1'b1;
              frame_done_q       <= (slot_q == LAST_SLOT);
              slot_q             <= slot_q + 2'd1;  // 3 wraps to 0: next beat expects sync
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign ch_a       = ch_q[0];
  assign ch_b       = ch_q[1];
  assign ch_c       = ch_q[2];
  assign ch_d       = ch_q[3];
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_4ch
//  Description : Self-checking bench for tdm_demux_4ch (WIDTH=8) against a
//                frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_4ch;

  localparam int W  = 8;
  localparam int VW = 4*W + 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] ch_a, ch_b, ch_c, ch_d;
  logic [3:0]   ch_valid;
  logic         frame_done, sync_err, locked;

  int checks = 0;
  int errors = 0;

  tdm_demux_4ch #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_a       (ch_a),
    .ch_b       (ch_b),
    .ch_c       (ch_c),
    .ch_d       (ch_d),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: position within frame ----------------
  bit           m_hunt;
  int           m_pos;      // bits received in the current frame
  int unsigned  m_acc;      // bits of the current slot as a number
  logic [W-1:0] m_ch [4];
  logic [3:0]   m_cv;
  logic         m_fd, m_se;

  typedef struct packed { logic v; logic fs; logic d; } beat_t;
  beat_t q[$];

  logic [VW-1:0] act_vec;
  assign act_vec = {ch_d, ch_c, ch_b, ch_a, ch_valid, frame_done, sync_err, locked};

  function automatic logic [VW-1:0] exp_vec();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0], m_cv, m_fd, m_se, !m_hunt};
  endfunction

  function automatic void model_reset();
    m_hunt = 1'b1; m_pos = 0; m_acc = 0;
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_cv = '0; m_fd = 1'b0; m_se = 1'b0;
  endfunction

  function automatic void model_beat(input logic v, input logic fs, input logic d);
    m_cv = '0; m_fd = 1'b0; m_se = 1'b0;
    if (!v) return;
    if (m_hunt) begin
      if (fs) begin m_hunt = 1'b0; m_pos = 1; m_acc = d; end
    end else if (m_pos == 0 && !fs) begin
      m_se = 1'b1; m_hunt = 1'b1;
    end else if (m_pos != 0 && fs) begin
      m_se = 1'b1; m_pos = 1; m_acc = d;
    end else begin
      m_acc = m_acc * 2 + d;
      m_pos++;
      if (m_pos % W == 0) begin
        m_ch[m_pos/W - 1] = m_acc[W-1:0];
        m_cv = 4'b0001 << (m_pos/W - 1);
        m_acc = 0;
        if (m_pos == 4*W) begin m_fd = 1'b1; m_pos = 0; end
      end
    end
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  function automatic void push_frame(input logic [W-1:0] a, b, c, d,
                                     input bit gap, input bit sync);
    logic [W-1:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int s = 0; s < 4; s++) begin
      for (int i = W-1; i >= 0; i--) begin
        if (gap) q.push_back(beat_t'{1'b0, 1'($urandom), 1'($urandom)});
        q.push_back(beat_t'{1'b1, logic'(sync && s == 0 && i == W-1), w[s][i]});
      end
    end
  endfunction

  task automatic beat(input beat_t b);
    din_valid = b.v; frame_sync = b.fs; din = b.d;
    @(posedge clk);
    model_beat(b.v, b.fs, b.d);
    #1;
  endtask

  task automatic do_reset(input logic junk);
    rst = 1'b1; din_valid = junk; frame_sync = junk; din = junk;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if (act_vec !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", act_vec);
    end
    beat(beat_t'{1'b1, 1'b0, 1'b1});
    checks++;
    if (locked !== 1'b0 || sync_err !== 1'b0) begin
      errors++; $display("FAIL reset_first_beat_hunt: got locked=%b sync_err=%b want 0 0", locked, sync_err);
    end
  endtask

  task automatic test_basic_frame();
    int idx[$]; logic [3:0] val[$]; int fd_cnt, se_cnt, fd_at; bit ok;
    fd_cnt = 0; se_cnt = 0; fd_at = -1;
    do_reset(1'b0);
    push_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      beat(q.pop_front());
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL basic beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (ch_valid != 0) begin idx.push_back(i); val.push_back(ch_valid); end
      if (frame_done) begin fd_cnt++; fd_at = i; end
      if (sync_err) se_cnt++;
    end
    checks++;
    if ({ch_a, ch_b, ch_c, ch_d} !== 32'hA53CFF00) begin
      errors++; $display("FAIL basic_words: got %h want a53cff00", {ch_a, ch_b, ch_c, ch_d});
    end
    ok = (idx.size() == 4);
    if (ok) for (int k = 0; k < 4; k++)
      if (val[k] !== (4'b0001 << k) || idx[k] != W-1 + W*k) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_strobes: got %0d strobes want 4 (1,2,4,8 spaced 8)", idx.size());
    end
    checks++;
    if (fd_cnt != 1 || idx.size() != 4 || fd_at != idx[idx.size()-1] || se_cnt != 0) begin
      errors++; $display("FAIL basic_frame_done: got fd=%0d at %0d se=%0d want fd=1 with ch_valid[3] se=0", fd_cnt, fd_at, se_cnt);
    end
  endtask

  task automatic test_gapped_frame();
    int idx[$]; bit ok;
    do_reset(1'b0);
    push_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      beat(q.pop_front());
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL gapped beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (ch_valid != 0) idx.push_back(i);
    end
    checks++;
    if ({ch_a, ch_b, ch_c, ch_d} !== 32'hA53CFF00) begin
      errors++; $display("FAIL gapped_words: got %h want a53cff00", {ch_a, ch_b, ch_c, ch_d});
    end
    ok = (idx.size() == 4);
    if (ok) for (int k = 1; k < 4; k++) if (idx[k] - idx[k-1] != 2*W) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL gapped_strobes: got %0d strobes want 4 spaced 16", idx.size());
    end
  endtask

  task automatic test_hunt_junk();
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) q.push_back(beat_t'{1'b1, 1'b0, 1'($urandom)});
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      beat(q.pop_front());
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL hunt beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
      checks++;
      if (locked !== logic'(i >= 12) || sync_err !== 1'b0) begin
        errors++; $display("FAIL hunt_lock beat %0d: got locked=%b se=%b want %b 0", i, locked, sync_err, i >= 12);
      end
    end
    checks++;
    if ({ch_a, ch_b, ch_c, ch_d} !== 32'h11223344) begin
      errors++; $display("FAIL hunt_words: got %h want 11223344", {ch_a, ch_b, ch_c, ch_d});
    end
  endtask

  task automatic test_missing_sync();
    int se_cnt; se_cnt = 0;
    do_reset(1'b0);
    push_frame(8'h5A, 8'hC3, 8'h81, 8'h7E, 1'b0, 1'b1);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; q.size() > 0; i++) begin
      beat(q.pop_front());
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL nosync beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (sync_err) se_cnt++;
      if (i == 4*W) begin
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
          errors++; $display("FAIL nosync_err: got se=%b locked=%b want 1 0", sync_err, locked);
        end
      end
    end
    checks++;
    if ({ch_a, ch_b, ch_c, ch_d} !== 32'h5AC3817E || se_cnt != 1) begin
      errors++; $display("FAIL nosync_retain: got %h se=%0d want 5ac3817e se=1", {ch_a, ch_b, ch_c, ch_d}, se_cnt);
    end
  endtask

  task automatic test_resync();
    do_reset(1'b0);
    push_frame(8'h10, 8'h77, 8'h20, 8'h30, 1'b0, 1'b1);
    push_frame(8'h5A, 8'h99, 8'hEE, 8'hEE, 1'b0, 1'b1);
    while (q.size() > 4*W + W + 3) void'(q.pop_back());  // up to bit 3 of slot 1
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      beat(q.pop_front());
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL resync beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (i == 4*W + W + 3) begin
        checks++;
        if (sync_err !== 1'b1 || ch_valid !== 4'b0 || ch_b !== 8'h77 || ch_a !== 8'h5A || locked !== 1'b1) begin
          errors++; $display("FAIL resync_err: got se=%b cv=%b b=%h a=%h lk=%b want 1 0000 77 5a 1",
                             sync_err, ch_valid, ch_b, ch_a, locked);
        end
      end
    end
    checks++;
    if ({ch_a, ch_b, ch_c, ch_d} !== 32'h01020304) begin
      errors++; $display("FAIL resync_words: got %h want 01020304", {ch_a, ch_b, ch_c, ch_d});
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    push_frame(8'hC3, 8'h3C, 8'h96, 8'h69, 1'b0, 1'b1);
    while (q.size() > 2*W + 5) void'(q.pop_back());  // up to bit 5 of slot 2
    while (q.size() > 0) beat(q.pop_front());
    do_reset(1'b1);
    checks++;
    if (act_vec !== '0) begin
      errors++; $display("FAIL midreset_zero: got %h want 0", act_vec);
    end
    push_frame(8'h0F, 8'hF0, 8'h55, 8'hAA, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      beat(q.pop_front());
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL midreset beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if ({ch_a, ch_b, ch_c, ch_d} !== 32'h0FF055AA || locked !== 1'b1) begin
      errors++; $display("FAIL midreset_relock: got %h lk=%b want 0ff055aa 1", {ch_a, ch_b, ch_c, ch_d}, locked);
    end
  endtask

  task automatic test_random();
    beat_t b;
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      b.v = ($urandom_range(0, 3) != 0);
      if (m_hunt || m_pos == 0) b.fs = ($urandom_range(0, 9) != 0);
      else                      b.fs = ($urandom_range(0, 199) == 0);
      b.d = 1'($urandom);
      beat(b);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random beat %0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_gapped_frame();
    test_hunt_junk();
    test_missing_sync();
    test_resync();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter WIDTH, default 8, bits per channel slot (legal 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  1  serial TDM data, MSB of each slot first.
REQ-005 din_valid  input  1  din and frame_sync sampled only when high.
REQ-006 frame_sync  input  1  marks first bit of slot 0 (channel a) of a frame.
REQ-007 ch_a, ch_b, ch_c, ch_d  output  WIDTH each  last completed word per channel, registered, held until overwritten.
REQ-008 ch_valid  output  4  one-cycle strobe per channel: bit0=a … bit3=d.
REQ-009 frame_done  output  1  one-cycle strobe when slot 3 (d) completes.
REQ-010 sync_err  output  1  one-cycle strobe on framing violation.
REQ-011 locked  output  1  high while in LOCK state.

Function
REQ-012 FSM states HUNT and LOCK; bit counter 0..WIDTH-1; slot counter 0..3.
REQ-013 HUNT: accepted beats (din_valid=1) with frame_sync=0 are discarded without error.
REQ-014 HUNT: accepted beat with frame_sync=1 -> LOCK, din becomes bit WIDTH-1 of slot 0, counters set to bit 1 / slot 0.
REQ-015 LOCK: each accepted beat shifts din into the slot shift register; beats with din_valid=0 change no state.
REQ-016 On the beat completing bit WIDTH-1 of slot s, the full word is written to ch_<s> and ch_valid[s] pulses in the following cycle (latency 1 clock from final bit sample).
REQ-017 Slot counter advances 0->1->2->3 on slot completion; completing slot 3 also pulses frame_done in the same cycle as ch_valid[3], and the next beat is expected to carry frame_sync.
REQ-018 LOCK, expected frame start, frame_sync=1: normal continuation, no error.
REQ-019 LOCK, expected frame start, frame_sync=0: sync_err pulses next cycle, beat discarded, state -> HUNT, locked falls.
REQ-020 LOCK, frame_sync=1 at any other position: sync_err pulses, partial slot discarded (no ch_valid), beat taken as bit WIDTH-1 of slot 0 of a new frame, remain in LOCK.
REQ-021 Channel words of slots completed before a violation are retained; no partial word ever reaches ch_*.
REQ-022 ch_valid, frame_done, sync_err are never high for more than one consecutive cycle per event.

Reset
REQ-023 rst=1 at a clock edge: state HUNT, counters 0, shift register 0, ch_a..ch_d 0, ch_valid 0, frame_done 0, sync_err 0, locked 0.
REQ-024 rst overrides all inputs including a simultaneous din_valid/frame_sync; mid-frame reset discards partial data with no strobes.
REQ-025 First beat accepted after rst deasserts follows HUNT rules.

Structure
REQ-026 Shared package tdm_pkg holds state enum (HUNT, LOCK), NUM_CH=4 and default WIDTH constant, shared with the matching 4-channel TDM multiplexer.
REQ-027 One sub-module, tdm_slot_shreg (WIDTH-bit shift register with clear and completion flag), instantiated once.

Verification (WIDTH=8)
REQ-028 Frame a=0xA5, b=0x3C, c=0xFF, d=0x00 with sync on first bit -> ch_a..ch_d equal those values, ch_valid strobes 1,2,4,8 each 8 beats apart, frame_done with ch_valid[3], sync_err never.
REQ-029 Same frame with din_valid low on every other cycle -> identical outputs, strobes delayed accordingly.
REQ-030 12 junk beats in HUNT then valid frame 0x11,0x22,0x33,0x44 -> only that frame captured, locked rises after sync beat.
REQ-031 Two frames back-to-back, second lacking frame_sync -> first frame captured, sync_err one cycle after second frame's first beat, locked=0.
REQ-032 frame_sync reasserted at bit 3 of slot 1 -> sync_err pulse, ch_b unchanged, new frame 0x01,0x02,0x03,0x04 captured correctly.
REQ-033 rst pulsed at bit 5 of slot 2 -> all outputs 0 next cycle, no strobes, relock on next frame_sync.
